// File: rtl/buffer_row_reader_pkg.sv
// Shared types for the operand-buffer row reader: FSM state encoding and counter sizing.
// Optional build macro: BUFFER_ROW_READER_TIMEOUT_EN (partial-row timeout flush).
package buffer_row_reader_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Width needed to count 0..row_len inclusive.
    function automatic int unsigned cnt_width(input int unsigned row_len);
        return $clog2(row_len + 1);
    endfunction

endpackage

// File: rtl/buffer_row_reader_if.sv
// Buffer-side read port and row-side valid/ready bus of the row reader.
// row_partial exists only when BUFFER_ROW_READER_TIMEOUT_EN is defined.
interface buffer_row_reader_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ROW_LEN    = 4
);
    logic                          buf_empty;
    logic [DATA_WIDTH-1:0]         buf_dout;
    logic                          buf_read_en;
    logic [ROW_LEN*DATA_WIDTH-1:0] row_data;
    logic                          row_valid;
    logic                          row_ready;
`ifdef BUFFER_ROW_READER_TIMEOUT_EN
    logic                          row_partial;
`endif

    // Reader side.
    modport master (
        input  buf_empty,
        input  buf_dout,
        input  row_ready,
`ifdef BUFFER_ROW_READER_TIMEOUT_EN
        output row_partial,
`endif
        output buf_read_en,
        output row_data,
        output row_valid
    );

    // Buffer / array-loader side.
    modport slave (
        output buf_empty,
        output buf_dout,
        output row_ready,
`ifdef BUFFER_ROW_READER_TIMEOUT_EN
        input  row_partial,
`endif
        input  buf_read_en,
        input  row_data,
        input  row_valid
    );

endinterface

// File: rtl/buffer_row_reader.sv
// Drains ROW_LEN words from a registered-output operand buffer and presents them as one row.
// Optional macro BUFFER_ROW_READER_TIMEOUT_EN flushes a stalled partial row, zero padded.
module buffer_row_reader
    import buffer_row_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ROW_LEN        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                clear,
    buffer_row_reader_if.master bus
);

    localparam int unsigned     CNT_W    = cnt_width(ROW_LEN);
    localparam int unsigned     IDX_W    = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
    localparam logic [CNT_W-1:0] ROW_FULL = CNT_W'(ROW_LEN);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(ROW_LEN - 1);

    if (ROW_LEN < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("buffer_row_reader: ROW_LEN must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    state_e                             state;
    state_e                             next_state;
    logic [CNT_W-1:0]                   issued;
    logic [CNT_W-1:0]                   captured;
    logic                               pending;
    logic [ROW_LEN-1:0][DATA_WIDTH-1:0] row_q;
    logic                               row_valid_q;

    logic read_c;
    logic handshake_c;
    logic last_capture_c;
    logic timeout_c;

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin : p_state
        if (!nRST) state <= FILL;
        else       state <= next_state;
    end

    // Next-state logic; clear overrides everything.
    always_comb begin : p_next
        next_state = state;
        if (clear) begin
            next_state = FILL;
        end else begin
            case (state)
                FILL:    if (last_capture_c || timeout_c) next_state = HOLD;
                HOLD:    if (handshake_c)                 next_state = FILL;
                default: next_state = FILL;
            endcase
        end
    end

    // Combinational decodes: read request, handshake, final capture.
    always_comb begin : p_out
        read_c         = 1'b0;
        handshake_c    = 1'b0;
        last_capture_c = 1'b0;
        if (state == FILL && issued < ROW_FULL && !bus.buf_empty && !clear) read_c = 1'b1;
        if (row_valid_q && bus.row_ready)                                   handshake_c = 1'b1;
        if (pending && captured == ROW_LAST)                                last_capture_c = 1'b1;
    end

    // Reset must silence the read request without waiting for a clock.
    assign bus.buf_read_en = read_c & nRST;
    assign bus.row_valid   = row_valid_q;
    assign bus.row_data    = row_q;

    // Read counters, in-flight flag and row assembly.
    always_ff @(posedge CLK or negedge nRST) begin : p_datapath
        if (!nRST) begin
            issued      <= '0;
            captured    <= '0;
            pending     <= 1'b0;
            row_q       <= '0;
            row_valid_q <= 1'b0;
        end else if (clear) begin
            issued      <= '0;
            captured    <= '0;
            pending     <= 1'b0;
            row_q       <= '0;
            row_valid_q <= 1'b0;
        end else begin
            pending     <= read_c;
            row_valid_q <= (next_state == HOLD);
            if (handshake_c) begin
                issued   <= '0;
                captured <= '0;
            end else begin
                if (read_c) issued <= issued + CNT_W'(1);
                if (pending) begin
                    row_q[IDX_W'(captured)] <= bus.buf_dout;
                    captured                <= captured + CNT_W'(1);
                end
`ifdef BUFFER_ROW_READER_TIMEOUT_EN
                // Slices never written for this row may still hold the previous row.
                if (timeout_c) begin
                    for (int i = 0; i < int'(ROW_LEN); i++) begin
                        if (CNT_W'(i) >= captured) row_q[i] <= '0;
                    end
                end
`endif
            end
        end
    end

`ifdef BUFFER_ROW_READER_TIMEOUT_EN
    localparam int unsigned     TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

    logic [TO_W-1:0] idle_cnt;
    logic            partial_q;
    logic            idle_c;

    // Idle only while a started row is starved and nothing is in flight.
    always_comb begin : p_idle
        idle_c = 1'b0;
        if (state == FILL && captured != '0 && captured < ROW_FULL && !pending && bus.buf_empty)
            idle_c = 1'b1;
    end

    assign timeout_c       = idle_c && (idle_cnt == TO_MAX);
    assign bus.row_partial = partial_q;

    always_ff @(posedge CLK or negedge nRST) begin : p_timeout
        if (!nRST) begin
            idle_cnt  <= '0;
            partial_q <= 1'b0;
        end else if (clear) begin
            idle_cnt  <= '0;
            partial_q <= 1'b0;
        end else begin
            if (read_c || handshake_c)         idle_cnt <= '0;
            else if (idle_c && idle_cnt != TO_MAX) idle_cnt <= idle_cnt + TO_W'(1);
            if (handshake_c)    partial_q <= 1'b0;
            else if (timeout_c) partial_q <= 1'b1;
        end
    end
`else
    assign timeout_c = 1'b0;
`endif

endmodule

// File: doc/buffer_row_reader.md
# buffer_row_reader

Consumer-side drain engine for the tensor core's circular operand buffers. It issues single-word reads against a buffer whose read data is registered: a word appears on the buffer's data output one cycle after an accepted read. It packs ROW_LEN consecutive words into one row vector and presents the row to the systolic-array loader over a valid/ready handshake. It sits between an operand buffer and the array-row input stage.

## Interface
- DATA_WIDTH, 32, width of one buffer word
- ROW_LEN, 4, words per output row (≥2)
- TIMEOUT_CYCLES, 16, idle cycles before a partial row is flushed (used only with the macro)
- CLK  in  1  clock, rising edge
- nRST  in  1  one clock; reset is asynchronous and active-low
- clear  in  1  synchronous flush, shared with the buffer's clear
- buf_empty  in  1  buffer empty flag
- buf_dout  in  DATA_WIDTH  buffer read data, valid the cycle after an accepted read
- buf_read_en  out  1  read request to the buffer
- row_data  out  ROW_LEN*DATA_WIDTH  packed row; word 0 occupies bits [DATA_WIDTH-1:0]
- row_valid  out  1  row_data holds a complete row
- row_ready  in  1  downstream accepts the row
- row_partial  out  1  row was zero-padded by timeout; present only with the macro

## Operation
- FSM states: FILL and HOLD. Reset state is FILL.
- Counters:
  - issued (0..ROW_LEN) counts accepted reads for the current row.
  - captured (0..ROW_LEN) counts words written into the row.
- buf_read_en is combinational: state==FILL && issued<ROW_LEN && !buf_empty && !clear.
- A read is accepted when buf_read_en=1. Acceptance sets the pending flag for the next cycle.
- When pending=1, buf_dout is written into slice [captured] and captured increments.
- When captured reaches ROW_LEN, the FSM moves to HOLD. In HOLD, row_valid=1 and row_data is stable.
- In HOLD, no reads are issued.
- row_valid && row_ready completes the handshake:
  - next cycle: FILL, both counters cleared, row_valid=0
  - row_data keeps its last value until it is overwritten
- row_ready is ignored while row_valid=0.
- clear, in any state:
  - next cycle: FILL, counters=0, pending=0, row_valid=0, row_partial=0, row_data=0
  - an in-flight word is discarded
- clear has priority over handshake completion and capture in the same cycle.
- If the buffer goes empty mid-row, the block stalls in FILL with captured words retained and resumes when buf_empty drops.
- Reset mid-row discards all state. All outputs reach their reset values immediately.

## Timing
- Reset values: buf_read_en=0, row_data=0, row_valid=0, row_partial=0.
- With the buffer never empty and the first accepted read in cycle t:
  - reads are accepted in cycles t..t+ROW_LEN-1
  - row_valid rises in cycle t+ROW_LEN+1
- Back-to-back rows, with row_ready held high: row_valid is high in 1 of every ROW_LEN+2 cycles.
  - the handshake cycle is followed by the first new read in the next cycle
- Throughput loss comes from the missing overlap between HOLD and FILL. This is accepted.

## Configuration
- Macro: BUFFER_ROW_READER_TIMEOUT_EN.
- Defined:
  - An idle counter runs in FILL while 0<captured<ROW_LEN, pending=0 and buf_empty=1. It resets on any accepted read.
  - When the counter reaches TIMEOUT_CYCLES, the FSM enters HOLD next cycle with row_partial=1.
  - Unfilled slices are zero.
  - row_partial clears on the handshake.
- Undefined:
  - no idle counter, no row_partial port
  - partial rows wait indefinitely

## Structure
- Package buffer_row_reader_pkg holds:
  - the state enum typedef (FILL, HOLD)
  - the counter width, computed as $clog2(ROW_LEN+1)
- No sub-module. The timeout counter is inline logic under the macro.

## Test plan
- Reset, then push 4 words 0x11,0x22,0x33,0x44 with ROW_LEN=4 and row_ready=1 -> row_valid for 1 cycle with row_data=0x00000044_00000033_00000022_00000011, exactly 5 cycles after the first read.
- Hold row_ready=0 for 10 cycles after row_valid -> row_data stable, buf_read_en=0 throughout; accepted on the first ready cycle.
- Make the buffer empty after 2 words, then refill 20 cycles later (macro off) -> stall with no reads while empty; the row completes with the correct order.
- Assert clear one cycle after the 3rd read is accepted -> the in-flight word is dropped, row_valid=0, the next row starts at slice 0.
- Macro on, TIMEOUT_CYCLES=16, 1 word 0xAB then empty -> after 16 idle cycles row_valid=1, row_partial=1, row_data=0xAB in slice 0, other slices zero.
- Deassert nRST while in HOLD -> row_valid, row_data and buf_read_en go to 0 immediately; normal operation follows.
